// File: rtl/jtb.sv
// jtb: set-associative jump target buffer, combinational lookup of pc and pc+4, tree-PLRU replacement.
// Define JTB_CONF_EN to add a 2-bit confidence counter per entry gating hits and dest replacement.
module jtb #(
   parameter int WAYS     = 4,
   parameter int SET_NUM  = 16,
   parameter int TAG_BITS = 18
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] lookup_pc,
   output logic [31:0] predict_pc,
   output logic        hit,
   output logic        hit_pc,
   output logic        hit_pcp4,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_dest,
   input  logic        flush,
   output logic        ready
);
   localparam int IB = $clog2(SET_NUM);
   localparam int WB = $clog2(WAYS);
   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]          state;
   logic [IB-1:0]       cnt;
   logic [WAYS-1:0]     valid_q [SET_NUM];
   logic [TAG_BITS-1:0] tag_q   [SET_NUM][WAYS];
   logic [31:0]         dest_q  [SET_NUM][WAYS];
   logic [WAYS-2:0]     plru_q  [SET_NUM];
`ifdef JTB_CONF_EN
   logic [1:0]          conf_q  [SET_NUM][WAYS];
`endif

   // Tree bit = 1 steers the victim to the right subtree; a touch points the path away from the way.
   function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] p, input logic [WB-1:0] w);
      logic [WAYS-2:0] r;
      int node;
      r = p;
      for (int l = 0; l < WB; l++) begin
         node = (1 << l) - 1 + int'(w >> (WB - l));
         for (int n = 0; n < WAYS - 1; n++)
            if (n == node) r[n] = ~w[WB-1-l];
      end
      return r;
   endfunction

   function automatic logic [WB-1:0] plru_victim(input logic [WAYS-2:0] p);
      logic [WB-1:0] v;
      int node;
      v = '0;
      for (int l = 0; l < WB; l++) begin
         node = (1 << l) - 1 + int'(v);
         for (int n = 0; n < WAYS - 1; n++)
            if (n == node) v = WB'({v, p[n]});
      end
      return v;
   endfunction

   logic                run;
   logic [31:0]         pcp4;
   logic [IB-1:0]       lk_set, up_set;
   logic [TAG_BITS-1:0] lk_tag, lk_tag4, up_tag;
   logic                hpc_w, hp4_w, match, has_inv, up_en;
   logic [WB-1:0]       way_pc, way_p4, hit_way, match_way, inv_way, up_way;
   logic                unused_bits;

   assign run     = (state == ST_RUN);
   assign pcp4    = lookup_pc + 32'd4;
   assign lk_set  = lookup_pc[IB+3:4];
   assign lk_tag  = lookup_pc[TAG_BITS+1:2];
   assign lk_tag4 = pcp4[TAG_BITS+1:2];
   assign up_set  = upd_pc[IB+3:4];
   assign up_tag  = upd_pc[TAG_BITS+1:2];
   assign up_en   = run & upd_valid & ~flush;
   assign unused_bits = ^{lookup_pc, pcp4, upd_pc};

   always_comb begin
      hpc_w     = 1'b0;
      hp4_w     = 1'b0;
      way_pc    = '0;
      way_p4    = '0;
      match     = 1'b0;
      match_way = '0;
      has_inv   = 1'b0;
      inv_way   = '0;
      // Descending scan so the lowest qualifying way is the one left standing.
      for (int w = WAYS - 1; w >= 0; w--) begin
`ifdef JTB_CONF_EN
         if (valid_q[lk_set][w] && conf_q[lk_set][w][1] && tag_q[lk_set][w] == lk_tag) begin
            hpc_w = 1'b1; way_pc = WB'(w);
         end
         if (valid_q[lk_set][w] && conf_q[lk_set][w][1] && tag_q[lk_set][w] == lk_tag4) begin
            hp4_w = 1'b1; way_p4 = WB'(w);
         end
`else
         if (valid_q[lk_set][w] && tag_q[lk_set][w] == lk_tag) begin
            hpc_w = 1'b1; way_pc = WB'(w);
         end
         if (valid_q[lk_set][w] && tag_q[lk_set][w] == lk_tag4) begin
            hp4_w = 1'b1; way_p4 = WB'(w);
         end
`endif
         if (valid_q[up_set][w] && tag_q[up_set][w] == up_tag) begin
            match = 1'b1; match_way = WB'(w);
         end
         if (!valid_q[up_set][w]) begin
            has_inv = 1'b1; inv_way = WB'(w);
         end
      end
   end

   assign hit_pc     = run & hpc_w;
   assign hit_pcp4   = run & hp4_w;
   assign hit        = hit_pc | hit_pcp4;
   assign hit_way    = hpc_w ? way_pc : way_p4;
   assign predict_pc = hit_pc ? dest_q[lk_set][way_pc] : (hit_pcp4 ? dest_q[lk_set][way_p4] : 32'd0);
   assign ready      = run;
   assign up_way     = match ? match_way : (has_inv ? inv_way : plru_victim(plru_q[up_set]));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_INIT;
         cnt   <= '0;
      end else if (state == ST_INIT) begin
         if (flush) begin
            cnt <= '0;
         end else if (cnt == IB'(SET_NUM - 1)) begin
            state <= ST_RUN;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else if (flush) begin
         state <= ST_INIT;
         cnt   <= '0;
      end
   end

   // Table storage needs no reset: the INIT sweep clears valid and PLRU before any use.
   always_ff @(posedge clk) begin
      if (state == ST_INIT) begin
         valid_q[cnt] <= '0;
         plru_q[cnt]  <= '0;
      end else begin
         if (hit && !(up_en && up_set == lk_set))
            plru_q[lk_set] <= plru_touch(plru_q[lk_set], hit_way);
         if (up_en) begin
            plru_q[up_set] <= plru_touch(plru_q[up_set], up_way);
            if (match) begin
`ifdef JTB_CONF_EN
               if (dest_q[up_set][up_way] == upd_dest) begin
                  if (conf_q[up_set][up_way] != 2'd3)
                     conf_q[up_set][up_way] <= conf_q[up_set][up_way] + 2'd1;
               end else if (conf_q[up_set][up_way] <= 2'd1) begin
                  dest_q[up_set][up_way] <= upd_dest;
                  conf_q[up_set][up_way] <= 2'd2;
               end else begin
                  conf_q[up_set][up_way] <= conf_q[up_set][up_way] - 2'd1;
               end
`else
               dest_q[up_set][up_way] <= upd_dest;
`endif
            end else begin
               valid_q[up_set][up_way] <= 1'b1;
               tag_q[up_set][up_way]   <= up_tag;
               dest_q[up_set][up_way]  <= upd_dest;
`ifdef JTB_CONF_EN
               conf_q[up_set][up_way]  <= 2'd2;
`endif
            end
         end
      end
   end
endmodule

// File: tb/tb_jtb.sv
// Randomised plus directed bench for jtb at default parameters against a table-level reference model.
module tb_jtb;
   localparam int WAYS = 4;
   localparam int SETS = 16;

   logic        clk = 1'b0;
   logic        reset, hit, hit_pc, hit_pcp4, upd_valid, flush, ready;
   logic [31:0] lookup_pc, predict_pc, upd_pc, upd_dest;

   always #5 clk = ~clk;

   jtb dut (
      .clk(clk), .reset(reset), .lookup_pc(lookup_pc), .predict_pc(predict_pc),
      .hit(hit), .hit_pc(hit_pc), .hit_pcp4(hit_pcp4), .upd_valid(upd_valid),
      .upd_pc(upd_pc), .upd_dest(upd_dest), .flush(flush), .ready(ready)
   );

   int n_chk = 0;
   int n_fail = 0;

   bit          m_run;
   int          m_cnt;
   bit          m_valid [SETS][WAYS];
   logic [17:0] m_tag   [SETS][WAYS];
   logic [31:0] m_dest  [SETS][WAYS];
   int          m_conf  [SETS][WAYS];
   bit          m_tree  [SETS][WAYS-1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int set_of(input logic [31:0] pc);
      return int'(pc[7:4]);
   endfunction

   function automatic logic [17:0] tag_of(input logic [31:0] pc);
      return pc[19:2];
   endfunction

   function automatic bit usable(input int s, input int w);
`ifdef JTB_CONF_EN
      return m_valid[s][w] && m_conf[s][w] >= 2;
`else
      return m_valid[s][w];
`endif
   endfunction

   function automatic int find(input int s, input logic [17:0] t, input bit need_use);
      for (int w = 0; w < WAYS; w++)
         if ((need_use ? usable(s, w) : m_valid[s][w]) && m_tag[s][w] == t) return w;
      return -1;
   endfunction

   // Walk the binary tree by halving the way range; bit 1 means the victim lies in the upper half.
   function automatic int victim(input int s);
      int lo = 0, size = WAYS, node = 0;
      while (size > 1) begin
         size = size / 2;
         if (m_tree[s][node]) begin lo += size; node = 2 * node + 2; end
         else node = 2 * node + 1;
      end
      return lo;
   endfunction

   task automatic touch(input int s, input int w);
      int lo = 0, size = WAYS, node = 0;
      while (size > 1) begin
         size = size / 2;
         if (w >= lo + size) begin m_tree[s][node] = 1'b0; lo += size; node = 2 * node + 2; end
         else begin m_tree[s][node] = 1'b1; node = 2 * node + 1; end
      end
   endtask

   task automatic model_out(input logic [31:0] pc, output bit e_hpc, output bit e_hp4,
                            output logic [31:0] e_pred, output int e_way);
      int s, a, b;
      s = set_of(pc);
      a = find(s, tag_of(pc), 1'b1);
      b = find(s, tag_of(pc + 32'd4), 1'b1);
      e_hpc = m_run && a >= 0;
      e_hp4 = m_run && b >= 0;
      e_way = (a >= 0) ? a : b;
      if (e_hpc) e_pred = m_dest[s][a];
      else if (e_hp4) e_pred = m_dest[s][b];
      else e_pred = 32'd0;
   endtask

   task automatic model_step(input logic [31:0] lk, input bit uv, input logic [31:0] up,
                             input logic [31:0] ud, input bit fl);
      bit hpc, hp4;
      logic [31:0] pred;
      int way, us, w;
      if (!m_run) begin
         for (int i = 0; i < WAYS; i++) m_valid[m_cnt][i] = 1'b0;
         for (int i = 0; i < WAYS - 1; i++) m_tree[m_cnt][i] = 1'b0;
         if (fl) m_cnt = 0;
         else if (m_cnt == SETS - 1) begin m_run = 1'b1; m_cnt = 0; end
         else m_cnt++;
         return;
      end
      if (fl) begin m_run = 1'b0; m_cnt = 0; return; end
      model_out(lk, hpc, hp4, pred, way);
      us = set_of(up);
      if ((hpc || hp4) && !(uv && us == set_of(lk))) touch(set_of(lk), way);
      if (uv) begin
         w = find(us, tag_of(up), 1'b0);
         if (w >= 0) begin
`ifdef JTB_CONF_EN
            if (m_dest[us][w] == ud) m_conf[us][w] = (m_conf[us][w] < 3) ? m_conf[us][w] + 1 : 3;
            else if (m_conf[us][w] <= 1) begin m_dest[us][w] = ud; m_conf[us][w] = 2; end
            else m_conf[us][w] = m_conf[us][w] - 1;
`else
            m_dest[us][w] = ud;
`endif
         end else begin
            for (int i = WAYS - 1; i >= 0; i--) if (!m_valid[us][i]) w = i;
            if (w < 0) w = victim(us);
            m_valid[us][w] = 1'b1;
            m_tag[us][w]   = tag_of(up);
            m_dest[us][w]  = ud;
            m_conf[us][w]  = 2;
         end
         touch(us, w);
      end
   endtask

   // One clock: drive at the falling edge, check outputs against the model, then advance both.
   task automatic cycle(input logic [31:0] lk, input bit uv, input logic [31:0] up,
                        input logic [31:0] ud, input bit fl);
      bit e_hpc, e_hp4;
      logic [31:0] e_pred;
      int e_way;
      lookup_pc = lk; upd_valid = uv; upd_pc = up; upd_dest = ud; flush = fl;
      #1;
      model_out(lk, e_hpc, e_hp4, e_pred, e_way);
      chk("ready", 32'(ready), 32'(m_run));
      chk("hit", 32'(hit), 32'(e_hpc | e_hp4));
      chk("hit_pc", 32'(hit_pc), 32'(e_hpc));
      chk("hit_pcp4", 32'(hit_pcp4), 32'(e_hp4));
      chk("predict_pc", predict_pc, e_pred);
      @(posedge clk);
      model_step(lk, uv, up, ud, fl);
      @(negedge clk);
   endtask

   task automatic look(input logic [31:0] pc);
      lookup_pc = pc; upd_valid = 1'b0; flush = 1'b0;
      #1;
   endtask

   function automatic logic [31:0] rpc();
      return 32'h80000000 | (32'($urandom_range(0, 2)) << 4) | (32'($urandom_range(0, 5)) << 8)
                          | (32'($urandom_range(0, 3)) << 2);
   endfunction

   localparam logic [31:0] IDLE_PC = 32'h90000050;

   initial begin
      int n;
      reset = 1'b1; lookup_pc = 32'h80001000; upd_valid = 1'b0; upd_pc = '0; upd_dest = '0; flush = 1'b0;
      m_run = 1'b0; m_cnt = 0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_hit", 32'({hit, hit_pc, hit_pcp4}), 32'd0);
      chk("rst_predict", predict_pc, 32'd0);
      reset = 1'b0;

      // Sweep after reset: updates offered here must be ignored.
      for (int i = 0; i < 16; i++) cycle(rpc(), 1'b1, rpc(), $urandom, 1'b0);
      look(IDLE_PC);
      chk("ready_after_16", 32'(ready), 32'd1);
      for (int i = 0; i < 8; i++) cycle(rpc(), 1'b0, '0, '0, 1'b0);

      cycle(IDLE_PC, 1'b1, 32'h80001000, 32'h80002000, 1'b0);
      look(32'h80001000);
      chk("basic_hit", 32'({hit, hit_pc}), 32'd3);
      chk("basic_pred", predict_pc, 32'h80002000);
      cycle(32'h80001000, 1'b0, '0, '0, 1'b0);
      cycle(IDLE_PC, 1'b1, 32'h80001008, 32'h80004000, 1'b0);
      look(32'h80001004);
      chk("pcp4_flags", 32'({hit_pc, hit_pcp4}), 32'd1);
      chk("pcp4_pred", predict_pc, 32'h80004000);
      cycle(IDLE_PC, 1'b1, 32'h80001004, 32'h80005000, 1'b0);
      look(32'h80001004);
      chk("prio_flags", 32'({hit_pc, hit_pcp4}), 32'd3);
      chk("prio_pred", predict_pc, 32'h80005000);

      cycle(IDLE_PC, 1'b1, 32'h80001000, 32'h80003000, 1'b0);
`ifdef JTB_CONF_EN
      look(32'h80001000);
      chk("conf_low_miss", 32'(hit_pc), 32'd0);
      cycle(IDLE_PC, 1'b1, 32'h80001000, 32'h80003000, 1'b0);
`endif
      look(32'h80001000);
      chk("redirect_pred", predict_pc, 32'h80003000);
      cycle(32'h80001000, 1'b0, '0, '0, 1'b0);

      cycle(IDLE_PC, 1'b0, '0, '0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         look(32'h80001000);
         chk("flush_not_ready", 32'(ready), 32'd0);
         cycle(32'h80001000, 1'b1, 32'h80001000, 32'h1, 1'b0);
      end
      look(32'h80001000);
      chk("flush_ready", 32'(ready), 32'd1);
      chk("flush_miss", 32'(hit), 32'd0);

      // Four tags fill set 0; touching way 0 makes way 2 the tree victim for the fifth.
      for (int k = 0; k < 4; k++) cycle(IDLE_PC, 1'b1, 32'h80000000 + 32'(k) * 32'h100, 32'hA0 + 32'(k), 1'b0);
      cycle(32'h80000000, 1'b0, '0, '0, 1'b0);
      cycle(IDLE_PC, 1'b1, 32'h80000400, 32'hA4, 1'b0);
      look(32'h80000000);
      chk("plru_keep_way0", predict_pc, 32'hA0);
      look(32'h80000200);
      chk("plru_evicted", 32'(hit), 32'd0);
      look(32'h80000400);
      chk("plru_new", predict_pc, 32'hA4);
      look(32'h80000300);
      chk("plru_keep_way3", predict_pc, 32'hA3);

      for (int i = 0; i < 1500; i++)
         cycle(($urandom_range(0, 3) == 0) ? $urandom : rpc(), 1'($urandom_range(0, 1)), rpc(),
               $urandom, ($urandom_range(0, 199) == 0));

      cycle(IDLE_PC, 1'b0, '0, '0, 1'b1);
      for (int i = 0; i < 7; i++) cycle(rpc(), 1'b0, '0, '0, 1'b0);
      reset = 1'b1;
      #1;
      m_run = 1'b0; m_cnt = 0;
      chk("async_rst_ready", 32'(ready), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      n = 0;
      while (!ready && n < 40) begin
         cycle(rpc(), 1'b0, '0, '0, 1'b0);
         n++;
      end
      chk("resweep_cycles", 32'(n), 32'd16);
      for (int k = 0; k < 6; k++) begin
         look(32'h80000000 + 32'(k) * 32'h100);
         chk("post_reset_miss", 32'(hit), 32'd0);
      end
      for (int i = 0; i < 50; i++) cycle(rpc(), 1'($urandom_range(0, 1)), rpc(), $urandom, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
